sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_pkg.sv | 25 ++
 rtl/sipo_tick.sv | 28 ++
 rtl/sipo_rx.sv | 148 ++++++++++++++
 tb/tb_sipo_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
// SIPO_RX_PARITY_EN adds one even-parity bit after the data bits of each frame.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned NP_DEF = 21;

`ifdef SIPO_RX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  // Total samples per frame: data bits plus optional parity bit.
  function automatic int unsigned frame_len(input int unsigned n);
    return n + PAR_BITS;
  endfunction

endpackage

// File: rtl/sipo_tick.sv
// Sample-tick prescaler: free-running NP-bit counter, tick while it is all-ones.
module sipo_tick #(
  parameter int unsigned NP = sipo_pkg::NP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [NP-1:0] cnt_q;
  logic [NP-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + NP'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out frame receiver, MSB first, one sample per prescaler tick.
// Macro SIPO_RX_PARITY_EN enables a trailing even-parity bit and the perr flag.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned NP = NP_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         serin,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         busy,
  output logic         perr
);

  localparam int unsigned FLEN = frame_len(N);
  localparam int unsigned BCW  = $clog2(FLEN + 1);

  state_e         state_q;
  state_e         state_d;
  logic [N-1:0]   shreg_q;
  logic [N-1:0]   shreg_d;
  logic [N-1:0]   data_q;
  logic [N-1:0]   data_d;
  logic [BCW-1:0] bitcnt_q;
  logic [BCW-1:0] bitcnt_d;
  logic           valid_q;
  logic           valid_d;
  logic           busy_q;
  logic           busy_d;
  logic           tick;
  logic           tick_clr_c;
  logic           last_c;
  logic           data_bit_c;

  sipo_tick #(
    .NP (NP)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr_c),
    .tick  (tick)
  );

  assign last_c = (bitcnt_q == BCW'(FLEN));

  // Frame control; outputs are registered from the next state so valid aligns with DONE.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    tick_clr_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          bitcnt_d   = '0;
          tick_clr_c = 1'b1;
        end
      end
      SHIFT: begin
        if (last_c) begin
          state_d = DONE;
          data_d  = shreg_q;
          valid_d = 1'b1;
        end else if (tick) begin
          bitcnt_d = bitcnt_q + BCW'(1);
          if (data_bit_c) begin
            shreg_d = {shreg_q[N-2:0], serin};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

`ifdef SIPO_RX_PARITY_EN
  logic par_q;
  logic par_d;
  logic perr_q;
  logic perr_d;

  // The parity tick only feeds the running XOR; the data shift register is left alone.
  assign data_bit_c = (bitcnt_q < BCW'(N));

  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    if (state_q == IDLE && start) begin
      par_d = 1'b0;
    end else if (state_q == SHIFT && !last_c && tick) begin
      par_d = par_q ^ serin;
    end
    if (state_q == SHIFT && last_c) begin
      perr_d = par_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign data_bit_c = 1'b1;
  assign perr       = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx (N=4, NP=2) against a cycle-timed frame model.
module tb_sipo_rx;

  localparam int unsigned N  = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned TP = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int unsigned L = N + 1;
`else
  localparam int unsigned L = N;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         serin;
  logic [N-1:0] data;
  logic         valid;
  logic         busy;
  logic         perr;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [N-1:0] exp_data = '0;

  sipo_rx #(
    .N  (N),
    .NP (NP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .serin (serin),
    .data  (data),
    .valid (valid),
    .busy  (busy),
    .perr  (perr)
  );

  always #5 clk = ~clk;

  // Start sampled at edge 0; samples at edges TP*(k+1); valid after edge TP*L+1; idle after TP*L+2.
  task automatic run_frame(input string name, input logic [N-1:0] bits, input logic pbit,
                           input bit hold_start, input bit pulse_mid);
    logic sbits [L];
    logic exp_perr;
    logic exp_v;
    logic exp_b;
    int   k;
    for (int i = 0; i < int'(N); i++) sbits[i] = bits[N-1-i];
`ifdef SIPO_RX_PARITY_EN
    sbits[N] = pbit;
    exp_perr = (^bits) ^ pbit;
`else
    exp_perr = 1'b0;
    if (pbit) exp_perr = 1'b0;
`endif
    start = 1'b1;
    serin = 1'($urandom);
    for (int c = 0; c <= int'(TP * L + 2); c++) begin
      @(negedge clk);
      exp_v = (c == int'(TP * L + 1));
      exp_b = (c <= int'(TP * L + 1));
      if (exp_v) exp_data = bits;
      n_checks++;
      if (valid !== exp_v) $display("FAIL %s valid c=%0d got %b expected %b", name, c, valid, exp_v);
      else n_pass++;
      n_checks++;
      if (busy !== exp_b) $display("FAIL %s busy c=%0d got %b expected %b", name, c, busy, exp_b);
      else n_pass++;
      n_checks++;
      if (data !== exp_data) $display("FAIL %s data c=%0d got %b expected %b", name, c, data, exp_data);
      else n_pass++;
      if (exp_v) begin
        n_checks++;
        if (perr !== exp_perr) $display("FAIL %s perr got %b expected %b", name, perr, exp_perr);
        else n_pass++;
      end
      start = hold_start || (pulse_mid && (c + 1 == 5 || c + 1 == 9));
      k = (c + 1) / int'(TP) - 1;
      if ((c + 1) % int'(TP) == 0 && k >= 0 && k < int'(L)) serin = sbits[k];
      else serin = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    serin = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset valid got %b expected 0", valid); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset busy got %b expected 0", busy); else n_pass++;
    n_checks++;
    if (data !== '0) $display("FAIL reset data got %b expected 0", data); else n_pass++;
    n_checks++;
    if (perr !== 1'b0) $display("FAIL reset perr got %b expected 0", perr); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release busy got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    start = 1'b1;
    serin = 1'($urandom);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 9) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midreset busy_before got %b expected 1", busy); else n_pass++;
      end
      start = 1'b0;
      serin = 1'($urandom);
    end
    rst_n = 1'b0;
    exp_data = '0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midreset busy got %b expected 0", busy); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      serin = 1'($urandom);
      n_checks++;
      if (valid !== 1'b0) $display("FAIL midreset valid c=%0d got %b expected 0", c, valid); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL midreset busy_idle c=%0d got %b expected 0", c, busy); else n_pass++;
      n_checks++;
      if (data !== '0) $display("FAIL midreset data c=%0d got %b expected 0", c, data); else n_pass++;
    end
    run_frame("after_reset", 4'b1101, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_single;
    run_frame("single_1011_p1", 4'b1011, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_frame("single_1011_p0", 4'b1011, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      run_frame("random", N'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_first", 4'b0110, 1'b0, 1'b1, 1'b0);
    run_frame("b2b_second", 4'b1001, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
  endtask

  task automatic test_start_ignored;
    @(negedge clk);
    run_frame("start_ignored", 4'b1011, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_single();
    test_back_to_back();
    test_start_ignored();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
